// File: rtl/sel_sort_engine.sv
// Selection-sort engine: sorts N words in place in an external single-port sync RAM.
// Latency: per row 2 + 2*(N-1-i) + (swap ? 2 : 0) + 1 cycles; 2 cycles start-to-done for N<=1.
// Backpressure: none; i_start is honoured only in IDLE, and o_busy marks a run in flight.
module sel_sort_engine #(
    parameter int SIZE_ADDR = 8,
    parameter int SIZE_DATA = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [SIZE_ADDR:0]   i_num_elems,
    input  logic                 i_descending,
    input  logic [SIZE_DATA-1:0] i_data_ram,
    output logic                 o_rd_en,
    output logic                 o_wr_en,
    output logic [SIZE_ADDR-1:0] o_addr_ram,
    output logic [SIZE_DATA-1:0] o_data_ram,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [SIZE_ADDR:0]   o_swap_cnt
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_I, S_CAP_I, S_RD_J, S_CMP_J, S_WR_I, S_WR_M, S_NEXT_I, S_DONE
    } state_t;

    localparam logic [SIZE_ADDR:0] ONE = 1;
    localparam logic [SIZE_ADDR:0] TWO = 2;

    state_t               r_state;
    logic [SIZE_ADDR:0]   r_n;
    logic                 r_desc;
    logic [SIZE_ADDR:0]   r_i;
    logic [SIZE_ADDR:0]   r_j;
    logic [SIZE_ADDR:0]   r_min_addr;
    logic [SIZE_DATA-1:0] r_key;
    logic [SIZE_DATA-1:0] r_min_val;

    logic                 w_better;
    logic [SIZE_DATA-1:0] w_min_val_nx;
    logic [SIZE_ADDR:0]   w_min_addr_nx;
    logic [SIZE_ADDR:0]   w_i_inc;
    logic [SIZE_ADDR:0]   w_j_inc;
    logic                 w_last_j;
    logic                 w_last_i;

    // Strict comparison keeps the first occurrence of a tied extreme as the row minimum.
    always_comb begin
        w_better      = r_desc ? (i_data_ram > r_min_val) : (i_data_ram < r_min_val);
        w_min_val_nx  = w_better ? i_data_ram : r_min_val;
        w_min_addr_nx = w_better ? r_j : r_min_addr;
        w_i_inc       = r_i + ONE;
        w_j_inc       = r_j + ONE;
        w_last_j      = (r_j == r_n - ONE);
        w_last_i      = (r_i == r_n - TWO);
    end

    // FSM with registered RAM strobes: each strobe is loaded on the edge that enters the
    // state performing the access, so read data lands exactly in the following state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_n        <= '0;
            r_desc     <= 1'b0;
            r_i        <= '0;
            r_j        <= '0;
            r_min_addr <= '0;
            r_key      <= '0;
            r_min_val  <= '0;
            o_rd_en    <= 1'b0;
            o_wr_en    <= 1'b0;
            o_addr_ram <= '0;
            o_data_ram <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_swap_cnt <= '0;
        end else begin
            o_rd_en <= 1'b0;
            o_wr_en <= 1'b0;
            o_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_n        <= i_num_elems;
                        r_desc     <= i_descending;
                        o_swap_cnt <= '0;
                        r_i        <= '0;
                        o_busy     <= 1'b1;
                        if (i_num_elems <= ONE) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state    <= S_RD_I;
                            o_rd_en    <= 1'b1;
                            o_addr_ram <= '0;
                        end
                    end
                end
                S_RD_I: begin
                    r_j        <= w_i_inc;
                    r_min_addr <= r_i;
                    r_state    <= S_CAP_I;
                end
                S_CAP_I: begin
                    r_key      <= i_data_ram;
                    r_min_val  <= i_data_ram;
                    r_state    <= S_RD_J;
                    o_rd_en    <= 1'b1;
                    o_addr_ram <= r_j[SIZE_ADDR-1:0];
                end
                S_RD_J: begin
                    r_state <= S_CMP_J;
                end
                S_CMP_J: begin
                    r_min_val  <= w_min_val_nx;
                    r_min_addr <= w_min_addr_nx;
                    if (w_last_j) begin
                        if (w_min_addr_nx != r_i) begin
                            r_state    <= S_WR_I;
                            o_wr_en    <= 1'b1;
                            o_addr_ram <= r_i[SIZE_ADDR-1:0];
                            o_data_ram <= w_min_val_nx;
                        end else begin
                            r_state <= S_NEXT_I;
                        end
                    end else begin
                        r_j        <= w_j_inc;
                        r_state    <= S_RD_J;
                        o_rd_en    <= 1'b1;
                        o_addr_ram <= w_j_inc[SIZE_ADDR-1:0];
                    end
                end
                S_WR_I: begin
                    r_state    <= S_WR_M;
                    o_wr_en    <= 1'b1;
                    o_addr_ram <= r_min_addr[SIZE_ADDR-1:0];
                    o_data_ram <= r_key;
                end
                S_WR_M: begin
                    o_swap_cnt <= o_swap_cnt + ONE;
                    r_state    <= S_NEXT_I;
                end
                S_NEXT_I: begin
                    if (w_last_i) begin
                        r_state <= S_DONE;
                    end else begin
                        r_i        <= w_i_inc;
                        r_state    <= S_RD_I;
                        o_rd_en    <= 1'b1;
                        o_addr_ram <= w_i_inc[SIZE_ADDR-1:0];
                    end
                end
                S_DONE: begin
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sel_sort_engine.sv
// Bench for sel_sort_engine: behavioural RAM, array-level selection-sort model, directed runs.
// Latency: model predicts start-to-done cycles from the row-cost formula.
// Backpressure: none; bench only drives i_start while idle except for the deliberate busy pulse.
module tb_sel_sort_engine;
    localparam int AW   = 3;
    localparam int DW   = 8;
    localparam int MAXN = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [AW:0]   i_num_elems = '0;
    logic          i_descending = 1'b0;
    logic [DW-1:0] rdata;
    logic          o_rd_en, o_wr_en, o_busy, o_done;
    logic [AW-1:0] o_addr_ram;
    logic [DW-1:0] o_data_ram;
    logic [AW:0]   o_swap_cnt;

    always #5 clk = ~clk;

    sel_sort_engine #(.SIZE_ADDR(AW), .SIZE_DATA(DW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_num_elems(i_num_elems),
        .i_descending(i_descending), .i_data_ram(rdata), .o_rd_en(o_rd_en), .o_wr_en(o_wr_en),
        .o_addr_ram(o_addr_ram), .o_data_ram(o_data_ram), .o_busy(o_busy), .o_done(o_done),
        .o_swap_cnt(o_swap_cnt)
    );

    logic [DW-1:0] mem [MAXN];
    logic [DW-1:0] init_mem [MAXN];
    logic          load = 1'b0;
    int            cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port synchronous RAM with a bulk preload path
    always @(posedge clk) begin
        if (load) mem <= init_mem;
        else if (o_wr_en) mem[o_addr_ram] <= o_data_ram;
        if (o_rd_en) rdata <= mem[o_addr_ram];
    end

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] stim [MAXN];
    logic [DW-1:0] expv [MAXN];
    int exp_swaps, exp_lat;

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Array-level selection sort: result, swap count and start-to-done cycle count
    task automatic model(input int n, input bit d);
        logic [DW-1:0] t;
        int m;
        expv = stim;
        exp_swaps = 0;
        exp_lat = 2;
        for (int i = 0; i < n - 1; i++) begin
            m = i;
            for (int j = i + 1; j < n; j++)
                if (d ? (expv[j] > expv[m]) : (expv[j] < expv[m])) m = j;
            exp_lat += 3 + 2 * (n - 1 - i);
            if (m != i) begin
                t = expv[i]; expv[i] = expv[m]; expv[m] = t;
                exp_swaps++;
                exp_lat += 2;
            end
        end
    endtask

    task automatic preload_and_start(input int n, input bit d, output int t0);
        @(negedge clk);
        init_mem = stim;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        i_start = 1'b1;
        i_num_elems = n[AW:0];
        i_descending = d;
        t0 = cyc;
    endtask

    task automatic run_sort(input string tag, input int n, input bit d, input bit mid_start,
                            output int rd_cnt, output int wr_cnt, output int lat);
        int t0, dn;
        bit got;
        model(n, d);
        preload_and_start(n, d, t0);
        got = 0; rd_cnt = 0; wr_cnt = 0; lat = 0;
        for (int c = 0; c < 4000 && !got; c++) begin
            @(negedge clk);
            i_start = mid_start && (c == 6);
            if (c == 0) begin
                i_num_elems  = ~i_num_elems;
                i_descending = ~d;
            end
            if (o_rd_en) rd_cnt++;
            if (o_wr_en) wr_cnt++;
            check({tag, "/rd_wr_excl"}, o_rd_en && o_wr_en, 0);
            if (o_rd_en || o_wr_en) check({tag, "/addr_range"}, o_addr_ram < n, 1);
            if (o_done) got = 1;
            else check({tag, "/busy"}, o_busy, 1);
        end
        i_start = 1'b0;
        if (!got) begin
            check({tag, "/done_timeout"}, 0, 1);
        end else begin
            lat = cyc - t0;
            check({tag, "/latency"}, lat, exp_lat);
            check({tag, "/busy_at_done"}, o_busy, 0);
            check({tag, "/swap_cnt"}, o_swap_cnt, exp_swaps);
            for (int k = 0; k < n; k++) check({tag, "/ram"}, mem[k], expv[k]);
            dn = 1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (o_done) dn++;
            end
            check({tag, "/done_pulses"}, dn, 1);
            check({tag, "/idle_busy"}, o_busy, 0);
            check({tag, "/swap_held"}, o_swap_cnt, exp_swaps);
        end
    endtask

    initial begin
        int rd, wr, lat, t0;
        bit hit_wr_m;
        logic prev_wr;
        logic [DW-1:0] lit [MAXN];

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outs", {o_rd_en, o_wr_en, o_busy, o_done, o_addr_ram, o_data_ram, o_swap_cnt}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outs", {o_rd_en, o_wr_en, o_busy, o_done, o_swap_cnt}, 0);

        // Ascending, one swap moves both ends
        stim = '{3, 1, 2, 0, 0, 0, 0, 0};
        run_sort("t1", 4, 0, 0, rd, wr, lat);
        check("t1_swap_lit", o_swap_cnt, 1);
        check("t1_lat_lit", lat, 25);

        // Descending, only rows 1..2 change
        stim = '{3, 1, 2, 0, 0, 0, 0, 0};
        run_sort("t2", 4, 1, 0, rd, wr, lat);
        check("t2_swap_lit", o_swap_cnt, 1);
        check("t2_lat_lit", lat, 25);

        // Already sorted: no writes at all
        stim = '{1, 2, 3, 4, 5, 0, 0, 0};
        run_sort("t3", 5, 0, 0, rd, wr, lat);
        check("t3_wr_lit", wr, 0);
        check("t3_swap_lit", o_swap_cnt, 0);
        check("t3_lat_lit", lat, 34);

        // Degenerate counts: no RAM traffic, done two cycles after start
        stim = '{9, 8, 7, 6, 5, 4, 3, 2};
        run_sort("t4n0", 0, 0, 0, rd, wr, lat);
        check("t4n0_rd_lit", rd + wr, 0);
        check("t4n0_lat_lit", lat, 2);
        run_sort("t4n1", 1, 1, 0, rd, wr, lat);
        check("t4n1_rd_lit", rd + wr, 0);
        check("t4n1_lat_lit", lat, 2);

        // Duplicates keep first occurrence as minimum
        stim = '{2, 2, 1, 1, 0, 0, 0, 0};
        run_sort("t5", 6, 0, 0, rd, wr, lat);
        lit = '{0, 0, 1, 1, 2, 2, 0, 0};
        for (int k = 0; k < 6; k++) check("t5_ram_lit", mem[k], lit[k]);
        check("t5_swap_lit", o_swap_cnt, 2);
        check("t5_lat_lit", lat, 51);

        // Reset during the second write of a swap, then a fresh run
        stim = '{7, 6, 5, 4, 3, 2, 1, 0};
        preload_and_start(8, 0, t0);
        hit_wr_m = 0;
        prev_wr = 1'b0;
        for (int c = 0; c < 200 && !hit_wr_m; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (prev_wr && o_wr_en) hit_wr_m = 1;
            prev_wr = o_wr_en;
        end
        check("t6_reached_wr_m", hit_wr_m, 1);
        rst_n = 1'b0;
        #1;
        check("t6_async_clear", {o_rd_en, o_wr_en, o_busy, o_done, o_swap_cnt}, 0);
        @(posedge clk);
        #1;
        check("t6_edge_clear", {o_rd_en, o_wr_en, o_busy, o_done, o_addr_ram, o_data_ram, o_swap_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sort("t6b", 8, 0, 0, rd, wr, lat);
        check("t6b_swap_lit", o_swap_cnt, 4);

        // Start pulse while busy must not restart the run
        stim = '{5, 200, 17, 17, 99, 0, 255, 42};
        run_sort("t7", 8, 1, 1, rd, wr, lat);

        // Random full-size runs, mixed value ranges to provoke ties
        for (int r = 0; r < 200; r++) begin
            for (int k = 0; k < MAXN; k++)
                stim[k] = DW'($urandom_range(0, (r % 3 == 0) ? 3 : 255));
            run_sort("rnd", MAXN, 1'($urandom_range(0, 1)), 0, rd, wr, lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
